// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
//
// Shared definitions for the branch predictor and its update-side queue.
//   BP_IDX_W     default predictor table index width
//   ctr_state_e  2-bit saturating counter state (SNT, WNT, WT, ST)
//   brq_entry_t  one buffered prediction: table index plus predicted direction
//   ctr_next()   counter training step, used by the predictor table
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_IDX_W = 10;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_state_e;

    typedef struct packed {
        logic [BP_IDX_W-1:0] index;
        logic                taken;
    } brq_entry_t;

    // Saturating step toward the actual outcome.
    function automatic ctr_state_e ctr_next(input ctr_state_e cur, input logic taken);
        ctr_state_e nxt;
        nxt = cur;
        if (taken && cur != ST) begin
            nxt = ctr_state_e'(cur + 2'd1);
        end else if (!taken && cur != SNT) begin
            nxt = ctr_state_e'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/brq_fifo.sv
// ---------------------------------------------------------------------------
// brq_fifo
//
// Circular buffer of DEPTH entries, DATA_W bits each. Head and tail pointers
// wrap modulo DEPTH (DEPTH must be a power of two). A flush empties the buffer
// at the next edge and takes priority over any push or pop in that cycle.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   push_en    in   write push_data at the tail (ignored when full)
//   push_data  in   entry to write
//   pop_en     in   retire the head entry (ignored when empty)
//   flush      in   discard all entries, pointers return to 0
//   head_data  out  entry currently at the head
//   count      out  occupied entries
// ---------------------------------------------------------------------------
module brq_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 11
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_en,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop_en,
    input  logic                       flush,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    // Guard against overflow/underflow here so the buffer stays coherent even
    // if a caller forgets to qualify its requests.
    assign push_ok = push_en && (count_q != CNT_W'(DEPTH)) && !flush;
    assign pop_ok  = pop_en  && (count_q != '0);

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (push_ok) begin
            mem_d[tail_q] = push_data;
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop_ok) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides which slots are live.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue
//
// Update-side companion to the 2-bit saturating-counter predictor table.
// Buffers each issued prediction in program order; when execute resolves the
// oldest branch it emits a registered one-cycle training update (index plus
// actual direction). A wrong prediction raises mispredict and discards every
// younger (wrong-path) entry, including a push arriving in the same cycle.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   pred_valid/index/taken, pred_ready   prediction push interface
//   res_valid, res_taken                 resolution of the oldest branch
//   upd_valid/index/taken                registered training update
//   mispredict        one-cycle pulse, aligned with upd_valid
//   res_orphan        one-cycle pulse: resolution with the queue empty
//   count             occupied entries
//
// Build option: define BRQ_STATS_EN to add 16-bit saturating outputs
// mispredict_count and update_count, both cleared by reset.
// ---------------------------------------------------------------------------
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = BP_IDX_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic [IDX_W-1:0]           pred_index,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       upd_valid,
    output logic [IDX_W-1:0]           upd_index,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic                       res_orphan,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]                mispredict_count,
    output logic [15:0]                update_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH+1);

    // Same layout as bp_pkg::brq_entry_t, but sized by this instance's IDX_W.
    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             taken;
    } entry_t;

    entry_t           push_entry;
    entry_t           head_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             pop_now;
    logic             mis_now;
    logic             push_now;
    logic             orphan_now;

    logic             upd_valid_q,  upd_valid_d;
    logic [IDX_W-1:0] upd_index_q,  upd_index_d;
    logic             upd_taken_q,  upd_taken_d;
    logic             mispredict_q, mispredict_d;
    logic             res_orphan_q, res_orphan_d;

    // pred_ready looks only at the registered count, so a resolution in the
    // same cycle never opens a slot combinationally.
    assign pred_ready = !reset && (fifo_count < CNT_W'(DEPTH));

    assign pop_now    = res_valid && (fifo_count != '0);
    assign mis_now    = pop_now && (head_entry.taken != res_taken);
    assign orphan_now = res_valid && (fifo_count == '0);
    // A push alongside a mispredicting resolution is on the wrong path.
    assign push_now   = pred_valid && pred_ready && !mis_now;

    assign push_entry = '{index: pred_index, taken: pred_taken};

    brq_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W ($bits(entry_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_en   (push_now),
        .push_data (push_entry),
        .pop_en    (pop_now),
        .flush     (mis_now),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    // Update stage: index/direction are only reloaded on a pop so the outputs
    // stay quiet between updates.
    always_comb begin
        upd_valid_d  = pop_now;
        upd_index_d  = upd_index_q;
        upd_taken_d  = upd_taken_q;
        mispredict_d = mis_now;
        res_orphan_d = orphan_now;
        if (pop_now) begin
            upd_index_d = head_entry.index;
            upd_taken_d = res_taken;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            upd_valid_q  <= 1'b0;
            upd_index_q  <= '0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            res_orphan_q <= 1'b0;
        end else begin
            upd_valid_q  <= upd_valid_d;
            upd_index_q  <= upd_index_d;
            upd_taken_q  <= upd_taken_d;
            mispredict_q <= mispredict_d;
            res_orphan_q <= res_orphan_d;
        end
    end

    assign upd_valid  = upd_valid_q;
    assign upd_index  = upd_index_q;
    assign upd_taken  = upd_taken_q;
    assign mispredict = mispredict_q;
    assign res_orphan = res_orphan_q;
    assign count      = fifo_count;

`ifdef BRQ_STATS_EN
    logic [15:0] mis_cnt_q, mis_cnt_d;
    logic [15:0] upd_cnt_q, upd_cnt_d;

    // Counters step on the same edge that raises the matching pulse, so the
    // value seen alongside a pulse already includes it.
    always_comb begin
        mis_cnt_d = mis_cnt_q;
        upd_cnt_d = upd_cnt_q;
        if (mispredict_d && mis_cnt_q != 16'hFFFF) begin
            mis_cnt_d = mis_cnt_q + 16'd1;
        end
        if (upd_valid_d && upd_cnt_q != 16'hFFFF) begin
            upd_cnt_d = upd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mis_cnt_q <= '0;
            upd_cnt_q <= '0;
        end else begin
            mis_cnt_q <= mis_cnt_d;
            upd_cnt_q <= upd_cnt_d;
        end
    end

    assign mispredict_count = mis_cnt_q;
    assign update_count     = upd_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_queue
//
// Directed test of branch_resolve_queue (DEPTH 8, IDX_W 10). Each scenario
// task drives its own stimulus and compares against hand-derived values.
// ---------------------------------------------------------------------------
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;
    localparam int IDX_W = 10;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             pred_valid;
    logic [IDX_W-1:0] pred_index;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic             upd_taken;
    logic             mispredict;
    logic             res_orphan;
    logic [CNT_W-1:0] count;
`ifdef BRQ_STATS_EN
    logic [15:0]      mispredict_count;
    logic [15:0]      update_count;
`endif

    int checks = 0;
    int passes = 0;

    branch_resolve_queue #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pred_valid (pred_valid),
        .pred_index (pred_index),
        .pred_taken (pred_taken),
        .pred_ready (pred_ready),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .upd_valid  (upd_valid),
        .upd_index  (upd_index),
        .upd_taken  (upd_taken),
        .mispredict (mispredict),
        .res_orphan (res_orphan),
        .count      (count)
`ifdef BRQ_STATS_EN
        ,
        .mispredict_count (mispredict_count),
        .update_count     (update_count)
`endif
    );

    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        pred_valid = 1'b0;
        pred_index = '0;
        pred_taken = 1'b0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        checks++; if (count !== 4'd0) $display("[TB] FAIL reset.count got=%0d exp=0", count); else passes++;
        checks++; if (upd_valid !== 1'b0) $display("[TB] FAIL reset.upd_valid got=%0b exp=0", upd_valid); else passes++;
        checks++; if (upd_index !== 10'd0) $display("[TB] FAIL reset.upd_index got=%0d exp=0", upd_index); else passes++;
        checks++; if (upd_taken !== 1'b0) $display("[TB] FAIL reset.upd_taken got=%0b exp=0", upd_taken); else passes++;
        checks++; if (mispredict !== 1'b0) $display("[TB] FAIL reset.mispredict got=%0b exp=0", mispredict); else passes++;
        checks++; if (res_orphan !== 1'b0) $display("[TB] FAIL reset.res_orphan got=%0b exp=0", res_orphan); else passes++;
        checks++; if (pred_ready !== 1'b0) $display("[TB] FAIL reset.pred_ready_in_reset got=%0b exp=0", pred_ready); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (pred_ready !== 1'b1) $display("[TB] FAIL reset.pred_ready_after got=%0b exp=1", pred_ready); else passes++;
    endtask

    task automatic test_single();
        pred_valid = 1'b1; pred_index = 10'd5; pred_taken = 1'b1;
        step();
        idle();
        checks++; if (count !== 4'd1) $display("[TB] FAIL single.count_push got=%0d exp=1", count); else passes++;
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        idle();
        checks++; if (upd_valid !== 1'b1) $display("[TB] FAIL single.upd_valid got=%0b exp=1", upd_valid); else passes++;
        checks++; if (upd_index !== 10'd5) $display("[TB] FAIL single.upd_index got=%0d exp=5", upd_index); else passes++;
        checks++; if (upd_taken !== 1'b1) $display("[TB] FAIL single.upd_taken got=%0b exp=1", upd_taken); else passes++;
        checks++; if (mispredict !== 1'b0) $display("[TB] FAIL single.mispredict got=%0b exp=0", mispredict); else passes++;
        checks++; if (count !== 4'd0) $display("[TB] FAIL single.count_pop got=%0d exp=0", count); else passes++;
        step();
        checks++; if (upd_valid !== 1'b0) $display("[TB] FAIL single.upd_valid_pulse got=%0b exp=0", upd_valid); else passes++;
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            pred_valid = 1'b1; pred_index = IDX_W'(i); pred_taken = 1'b0;
            step();
        end
        checks++; if (count !== 4'd8) $display("[TB] FAIL full.count got=%0d exp=8", count); else passes++;
        checks++; if (pred_ready !== 1'b0) $display("[TB] FAIL full.pred_ready got=%0b exp=0", pred_ready); else passes++;
        pred_index = 10'd9;
        step();
        checks++; if (count !== 4'd8) $display("[TB] FAIL full.ninth_push got=%0d exp=8", count); else passes++;
        // Pop while still offering index 9: full means the push is refused.
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        idle();
        checks++; if (count !== 4'd7) $display("[TB] FAIL full.pop_while_full got=%0d exp=7", count); else passes++;
        checks++; if (pred_ready !== 1'b1) $display("[TB] FAIL full.ready_restored got=%0b exp=1", pred_ready); else passes++;
        checks++; if (upd_index !== 10'd0) $display("[TB] FAIL full.first_update got=%0d exp=0", upd_index); else passes++;
        for (int j = 1; j < DEPTH; j++) begin
            res_valid = 1'b1; res_taken = 1'b0;
            step();
            checks++; if (upd_valid !== 1'b1 || upd_index !== IDX_W'(j)) $display("[TB] FAIL full.drain_%0d got=%0b/%0d exp=1/%0d", j, upd_valid, upd_index, j); else passes++;
        end
        idle();
        checks++; if (count !== 4'd0) $display("[TB] FAIL full.drained got=%0d exp=0", count); else passes++;
        step();
        checks++; if (upd_valid !== 1'b0) $display("[TB] FAIL full.no_ninth_entry got=%0b exp=0", upd_valid); else passes++;
    endtask

    task automatic test_mispredict();
        for (int i = 1; i <= 3; i++) begin
            pred_valid = 1'b1; pred_index = IDX_W'(i); pred_taken = 1'b1;
            step();
        end
        pred_index = 10'd4;
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        idle();
        checks++; if (upd_valid !== 1'b1) $display("[TB] FAIL mis.upd_valid got=%0b exp=1", upd_valid); else passes++;
        checks++; if (upd_index !== 10'd1) $display("[TB] FAIL mis.upd_index got=%0d exp=1", upd_index); else passes++;
        checks++; if (upd_taken !== 1'b0) $display("[TB] FAIL mis.upd_taken got=%0b exp=0", upd_taken); else passes++;
        checks++; if (mispredict !== 1'b1) $display("[TB] FAIL mis.mispredict got=%0b exp=1", mispredict); else passes++;
        checks++; if (count !== 4'd0) $display("[TB] FAIL mis.flush_count got=%0d exp=0", count); else passes++;
        step();
        checks++; if (mispredict !== 1'b0) $display("[TB] FAIL mis.pulse_width got=%0b exp=0", mispredict); else passes++;
        checks++; if (count !== 4'd0) $display("[TB] FAIL mis.index4_dropped got=%0d exp=0", count); else passes++;
        pred_valid = 1'b1; pred_index = 10'd6; pred_taken = 1'b0;
        step();
        idle();
        checks++; if (count !== 4'd1) $display("[TB] FAIL mis.push_after_flush got=%0d exp=1", count); else passes++;
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        idle();
        checks++; if (upd_index !== 10'd6 || mispredict !== 1'b0) $display("[TB] FAIL mis.resume got=%0d/%0b exp=6/0", upd_index, mispredict); else passes++;
        step();
    endtask

    task automatic test_orphan();
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        idle();
        checks++; if (res_orphan !== 1'b1) $display("[TB] FAIL orphan.pulse got=%0b exp=1", res_orphan); else passes++;
        checks++; if (upd_valid !== 1'b0) $display("[TB] FAIL orphan.upd_valid got=%0b exp=0", upd_valid); else passes++;
        checks++; if (count !== 4'd0) $display("[TB] FAIL orphan.count got=%0d exp=0", count); else passes++;
        step();
        checks++; if (res_orphan !== 1'b0) $display("[TB] FAIL orphan.pulse_width got=%0b exp=0", res_orphan); else passes++;
    endtask

    // Entry k carries index 100+k, predicted taken = k odd.
    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            pred_valid = 1'b1; pred_index = IDX_W'(100 + i); pred_taken = i[0];
            step();
        end
        idle();
        checks++; if (count !== 4'd6) $display("[TB] FAIL b2b.fill got=%0d exp=6", count); else passes++;
        for (int k = 0; k < 20; k++) begin
            automatic int nk = k + 6;
            pred_valid = 1'b1; pred_index = IDX_W'(100 + nk); pred_taken = nk[0];
            res_valid  = 1'b1; res_taken  = k[0];
            step();
            checks++; if (upd_valid !== 1'b1 || upd_index !== IDX_W'(100 + k) || upd_taken !== k[0]) $display("[TB] FAIL b2b.update_%0d got=%0b/%0d/%0b exp=1/%0d/%0b", k, upd_valid, upd_index, upd_taken, 100 + k, k[0]); else passes++;
            checks++; if (mispredict !== 1'b0 || count !== 4'd6) $display("[TB] FAIL b2b.state_%0d got=%0b/%0d exp=0/6", k, mispredict, count); else passes++;
        end
        idle();
    endtask

    // Queue holds 120..125 on entry; two pops leave 122..125.
    task automatic test_reset_mid();
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        res_taken = 1'b1;
        step();
        idle();
        checks++; if (count !== 4'd4) $display("[TB] FAIL rst_mid.pre_count got=%0d exp=4", count); else passes++;
        res_valid = 1'b1; res_taken = 1'b1;
        pred_valid = 1'b1; pred_index = 10'd200; pred_taken = 1'b0;
        reset = 1'b1;
        step();
        idle();
        checks++; if (upd_valid !== 1'b0) $display("[TB] FAIL rst_mid.upd_valid got=%0b exp=0", upd_valid); else passes++;
        checks++; if (mispredict !== 1'b0) $display("[TB] FAIL rst_mid.mispredict got=%0b exp=0", mispredict); else passes++;
        checks++; if (count !== 4'd0) $display("[TB] FAIL rst_mid.count got=%0d exp=0", count); else passes++;
        checks++; if (pred_ready !== 1'b0) $display("[TB] FAIL rst_mid.pred_ready got=%0b exp=0", pred_ready); else passes++;
`ifdef BRQ_STATS_EN
        checks++; if (mispredict_count !== 16'd0 || update_count !== 16'd0) $display("[TB] FAIL rst_mid.stats got=%0d/%0d exp=0/0", mispredict_count, update_count); else passes++;
`endif
        reset = 1'b0;
        #1;
        checks++; if (pred_ready !== 1'b1) $display("[TB] FAIL rst_mid.ready_after got=%0b exp=1", pred_ready); else passes++;
        pred_valid = 1'b1; pred_index = 10'd7; pred_taken = 1'b1;
        step();
        idle();
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        idle();
        checks++; if (upd_valid !== 1'b1 || upd_index !== 10'd7 || count !== 4'd0) $display("[TB] FAIL rst_mid.clean_restart got=%0b/%0d/%0d exp=1/7/0", upd_valid, upd_index, count); else passes++;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_single();
        test_full();
        test_mispredict();
        test_orphan();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
